// File: rtl/ddc_pkg.sv
// Shared widths, derived CIC sizing and the offset-binary conversion for the DDC mixer/CIC slice.
package ddc_pkg;

  localparam int ADC_W    = 8;
  localparam int NCO_W    = 10;
  localparam int DEC_LOG2 = 6;
  localparam int DEC      = 1 << DEC_LOG2;
  localparam int OUT_W    = 16;
  localparam int PROD_W   = ADC_W + NCO_W;
  localparam int CIC_W    = PROD_W + 3 * DEC_LOG2;
  localparam int TRUNC    = CIC_W - OUT_W;

  // Offset binary to two's complement is just an MSB flip.
  function automatic logic signed [ADC_W-1:0] ob_to_signed(input logic [ADC_W-1:0] x);
    return $signed({~x[ADC_W-1], x[ADC_W-2:0]});
  endfunction

endpackage

// File: rtl/ddc_mixer_cic_cic_dec3.sv
// One CIC channel: three integrators at input rate, three decimated-rate combs.
// Latency: integrator 3 holds a product 3 enabled clocks after prod_vld; comb output is combinational.
// Backpressure: none; clken=0 freezes every register.
module cic_dec3
  import ddc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clken,
  input  logic signed [PROD_W-1:0] prod,
  input  logic                     prod_vld,
  input  logic                     dec_stb,
  output logic        [OUT_W-1:0]  comb_top
);

  logic signed [CIC_W-1:0] int1, int2, int3;
  logic signed [CIC_W-1:0] dly1, dly2, dly3;
  logic signed [CIC_W-1:0] comb1, comb2, comb3;
  logic                    int2_vld, int3_vld;
  logic                    unused_lsb;

  // Integrators wrap modulo 2^CIC_W; the combs undo the wrap exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int1     <= '0;
      int2     <= '0;
      int3     <= '0;
      int2_vld <= 1'b0;
      int3_vld <= 1'b0;
    end else if (clken) begin
      int2_vld <= prod_vld;
      int3_vld <= int2_vld;
      if (prod_vld) int1 <= int1 + CIC_W'(prod);
      if (int2_vld) int2 <= int2 + int1;
      if (int3_vld) int3 <= int3 + int2;
    end
  end

  always_comb begin
    comb1 = int3 - dly1;
    comb2 = comb1 - dly2;
    comb3 = comb2 - dly3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly1 <= '0;
      dly2 <= '0;
      dly3 <= '0;
    end else if (clken && dec_stb) begin
      dly1 <= int3;
      dly2 <= comb1;
      dly3 <= comb2;
    end
  end

  // Plain truncation to the output width; the dropped LSBs are intentionally discarded.
  assign comb_top   = comb3[CIC_W-1 -: OUT_W];
  assign unused_lsb = ^comb3[TRUNC-1:0];

endmodule

// File: rtl/ddc_mixer_cic.sv
// Quadrature mixer (ADC x NCO cos/sin) feeding two CIC-3 decimators, producing I/Q at Fs/DEC.
// Latency: 5 enabled clocks from acceptance of the DEC-th sample to out_valid.
// Backpressure: none; clken=0 stalls the whole pipeline and masks out_valid.
module ddc_mixer_cic
  import ddc_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  input  logic [ADC_W-1:0] adc_i,
  input  logic             nco_valid_i,
  input  logic [NCO_W-1:0] nco_sin_i,
  input  logic [NCO_W-1:0] nco_cos_i,
  output logic [OUT_W-1:0] out_i,
  output logic [OUT_W-1:0] out_q,
  output logic             out_valid
);

  localparam logic [DEC_LOG2-1:0] CNT_LAST = DEC_LOG2'(DEC - 1);

  logic                     in_ok;
  logic                     cap_vld;
  logic signed [ADC_W-1:0]  adc_s;
  logic signed [NCO_W-1:0]  sin_s, cos_s;
  logic signed [PROD_W-1:0] prod_i, prod_q;
  logic                     prod_vld, int2_vld, int3_vld;
  logic [DEC_LOG2-1:0]      dec_cnt;
  logic                     dec_stb;
  logic                     out_vld;
  logic [OUT_W-1:0]         comb_i, comb_q;

  assign in_ok = clken & nco_valid_i;

  // E0 capture and E1 multiply.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_vld  <= 1'b0;
      adc_s    <= '0;
      sin_s    <= '0;
      cos_s    <= '0;
      prod_vld <= 1'b0;
      prod_i   <= '0;
      prod_q   <= '0;
    end else if (clken) begin
      cap_vld  <= nco_valid_i;
      prod_vld <= cap_vld;
      if (in_ok) begin
        adc_s <= ob_to_signed(adc_i);
        sin_s <= $signed(nco_sin_i);
        cos_s <= $signed(nco_cos_i);
      end
      if (cap_vld) begin
        prod_i <= PROD_W'(adc_s) * PROD_W'(cos_s);
        prod_q <= PROD_W'(adc_s) * PROD_W'(sin_s);
      end
    end
  end

  // Valid shadow of the integrator chain drives the shared I/Q decimation counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int2_vld <= 1'b0;
      int3_vld <= 1'b0;
      dec_cnt  <= '0;
      dec_stb  <= 1'b0;
    end else if (clken) begin
      int2_vld <= prod_vld;
      int3_vld <= int2_vld;
      dec_stb  <= int3_vld && (dec_cnt == CNT_LAST);
      if (int3_vld) begin
        if (dec_cnt == CNT_LAST) dec_cnt <= '0;
        else                     dec_cnt <= dec_cnt + DEC_LOG2'(1);
      end
    end
  end

  cic_dec3 u_cic_i (
    .clk      (clk),
    .reset_n  (reset_n),
    .clken    (clken),
    .prod     (prod_i),
    .prod_vld (prod_vld),
    .dec_stb  (dec_stb),
    .comb_top (comb_i)
  );

  cic_dec3 u_cic_q (
    .clk      (clk),
    .reset_n  (reset_n),
    .clken    (clken),
    .prod     (prod_q),
    .prod_vld (prod_vld),
    .dec_stb  (dec_stb),
    .comb_top (comb_q)
  );

  // E5 output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld <= 1'b0;
      out_i   <= '0;
      out_q   <= '0;
    end else if (clken) begin
      out_vld <= dec_stb;
      if (dec_stb) begin
        out_i <= comb_i;
        out_q <= comb_q;
      end
    end
  end

  // A strobe held across a clken gap is only presented once enables resume.
  assign out_valid = out_vld & clken;

endmodule

// File: tb/tb_ddc_mixer_cic.sv
// Self-checking bench: mixer + CIC-3 decimator against a direct FIR-form reference (boxcar^3 impulse response).
module tb_ddc_mixer_cic;
  import ddc_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n, clken, nco_valid_i, out_valid;
  logic [ADC_W-1:0] adc_i;
  logic [NCO_W-1:0] nco_sin_i, nco_cos_i;
  logic [OUT_W-1:0] out_i, out_q;

  ddc_mixer_cic dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clken       (clken),
    .adc_i       (adc_i),
    .nco_valid_i (nco_valid_i),
    .nco_sin_i   (nco_sin_i),
    .nco_cos_i   (nco_cos_i),
    .out_i       (out_i),
    .out_q       (out_q),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tick_n = 0;

  // Reference model state
  longint           h[3*DEC-2];
  longint           xi[$], xq[$];
  int               acc, en_edges;
  int               due_q[$];
  longint           yi_q[$], yq_q[$];
  logic             exp_ov, exp_vis;
  logic [OUT_W-1:0] exp_i, exp_q;
  logic             p_ce, p_vl;
  logic [ADC_W-1:0] p_a;
  logic [NCO_W-1:0] p_s, p_c;

  task automatic build_h();
    longint h2[2*DEC-1];
    foreach (h2[k]) h2[k] = 0;
    foreach (h[k]) h[k] = 0;
    for (int i = 0; i < DEC; i++)
      for (int j = 0; j < DEC; j++) h2[i+j] += 1;
    for (int k = 0; k < 2*DEC-1; k++)
      for (int j = 0; j < DEC; j++) h[k+j] += h2[k];
  endtask

  function automatic longint cic_ref(input longint x[$]);
    longint y = 0;
    int n = x.size() - 1;
    for (int k = 0; k < 3*DEC-2 && k <= n; k++) y += h[k] * x[n-k];
    return y >>> (CIC_W - OUT_W);
  endfunction

  // Applies the rules for one posedge using the inputs that were presented to it.
  task automatic model_edge();
    longint a_s;
    if (p_ce) begin
      en_edges++;
      exp_ov = 1'b0;
      if (due_q.size() > 0 && due_q[0] == en_edges) begin
        void'(due_q.pop_front());
        exp_i  = OUT_W'(yi_q.pop_front());
        exp_q  = OUT_W'(yq_q.pop_front());
        exp_ov = 1'b1;
      end
      if (p_vl) begin
        a_s = longint'(p_a) - longint'(1 << (ADC_W-1));
        xi.push_back(a_s * longint'($signed(p_c)));
        xq.push_back(a_s * longint'($signed(p_s)));
        acc++;
        if (acc % DEC == 0) begin
          due_q.push_back(en_edges + 5);
          yi_q.push_back(cic_ref(xi));
          yq_q.push_back(cic_ref(xq));
        end
      end
    end
  endtask

  task automatic tick(input logic ce, input logic vl, input logic [ADC_W-1:0] a,
                      input logic [NCO_W-1:0] s, input logic [NCO_W-1:0] c);
    @(negedge clk);
    if (reset_n) model_edge();
    reset_n = 1'b1;
    clken = ce; nco_valid_i = vl; adc_i = a; nco_sin_i = s; nco_cos_i = c;
    p_ce = ce; p_vl = vl; p_a = a; p_s = s; p_c = c;
    exp_vis = exp_ov & ce;
    tick_n++;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    if (reset_n) model_edge();
    reset_n = 1'b0;
    xi.delete(); xq.delete(); due_q.delete(); yi_q.delete(); yq_q.delete();
    acc = 0; en_edges = 0;
    exp_ov = 1'b0; exp_vis = 1'b0; exp_i = '0; exp_q = '0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (out_i !== '0) begin bad++; $display("FAIL reset_out_i: got %0d want 0", $signed(out_i)); end
    total++;
    if (out_q !== '0) begin bad++; $display("FAIL reset_out_q: got %0d want 0", $signed(out_q)); end
    total++;
  endtask

  task automatic test_dc_pos();
    int n_out = 0, t_last = 0, t_prev = 0;
    pulse_reset();
    for (int t = 0; t < 5*DEC+10; t++) begin
      tick(1'b1, 1'b1, 8'hFF, '0, NCO_W'(511));
      if ({out_valid, out_i, out_q} !== {exp_vis, exp_i, exp_q}) begin
        bad++;
        $display("FAIL dc_pos_model tick=%0d: got v=%b i=%0d q=%0d want v=%b i=%0d q=%0d", tick_n,
                 out_valid, $signed(out_i), $signed(out_q), exp_vis, $signed(exp_i), $signed(exp_q));
      end
      total++;
      if (out_valid) begin
        n_out++; t_prev = t_last; t_last = tick_n;
        if (n_out >= 4) begin
          if (out_i !== 16'd16224 || out_q !== 16'd0) begin
            bad++;
            $display("FAIL dc_pos_steady: got i=%0d q=%0d want i=16224 q=0", $signed(out_i), $signed(out_q));
          end
          total++;
        end
      end
    end
    if (n_out != 5) begin bad++; $display("FAIL dc_pos_count: got %0d want 5", n_out); end
    total++;
    if (t_last - t_prev != DEC) begin bad++; $display("FAIL dc_pos_period: got %0d want %0d", t_last - t_prev, DEC); end
    total++;
  endtask

  task automatic test_dc_neg();
    int n_out;
    logic [NCO_W-1:0] s, c;
    pulse_reset();
    for (int ph = 0; ph < 2; ph++) begin
      n_out = 0;
      s = (ph == 0) ? NCO_W'(0) : NCO_W'(511);
      c = (ph == 0) ? NCO_W'(511) : NCO_W'(0);
      for (int t = 0; t < 6*DEC; t++) begin
        tick(1'b1, 1'b1, 8'h00, s, c);
        if ({out_valid, out_i, out_q} !== {exp_vis, exp_i, exp_q}) begin
          bad++;
          $display("FAIL dc_neg_model tick=%0d: got v=%b i=%0d q=%0d want v=%b i=%0d q=%0d", tick_n,
                   out_valid, $signed(out_i), $signed(out_q), exp_vis, $signed(exp_i), $signed(exp_q));
        end
        total++;
        if (out_valid) begin
          n_out++;
          if (n_out >= 4) begin
            if ((ph == 0 && (out_i !== 16'(-16352) || out_q !== 16'd0)) ||
                (ph == 1 && (out_q !== 16'(-16352) || out_i !== 16'd0))) begin
              bad++;
              $display("FAIL dc_neg_steady ph=%0d: got i=%0d q=%0d want -16352 on the driven channel, 0 on the other",
                       ph, $signed(out_i), $signed(out_q));
            end
            total++;
          end
        end
      end
    end
  endtask

  task automatic test_midscale();
    int n_out = 0;
    pulse_reset();
    for (int t = 0; t < 4*DEC+10; t++) begin
      tick(1'b1, 1'b1, 8'h80, NCO_W'($urandom), NCO_W'($urandom));
      if ({out_valid, out_i, out_q} !== {exp_vis, exp_i, exp_q}) begin
        bad++;
        $display("FAIL mid_model tick=%0d: got v=%b i=%0d q=%0d want v=%b i=%0d q=%0d", tick_n,
                 out_valid, $signed(out_i), $signed(out_q), exp_vis, $signed(exp_i), $signed(exp_q));
      end
      total++;
      if (out_valid) begin
        n_out++;
        if (out_i !== '0 || out_q !== '0) begin
          bad++; $display("FAIL mid_zero: got i=%0d q=%0d want 0 0", $signed(out_i), $signed(out_q));
        end
        total++;
      end
    end
    if (n_out != 4) begin bad++; $display("FAIL mid_count: got %0d want 4", n_out); end
    total++;
  endtask

  task automatic test_gapped();
    int n_out = 0, t_last = 0, t_prev = 0;
    pulse_reset();
    for (int t = 0; t < 8*DEC+20; t++) begin
      tick(1'b1, (t % 2) == 0, 8'hFF, '0, NCO_W'(511));
      if ({out_valid, out_i, out_q} !== {exp_vis, exp_i, exp_q}) begin
        bad++;
        $display("FAIL gap_model tick=%0d: got v=%b i=%0d q=%0d want v=%b i=%0d q=%0d", tick_n,
                 out_valid, $signed(out_i), $signed(out_q), exp_vis, $signed(exp_i), $signed(exp_q));
      end
      total++;
      if (out_valid) begin
        n_out++; t_prev = t_last; t_last = tick_n;
        if (n_out >= 4) begin
          if (out_i !== 16'd16224 || out_q !== 16'd0) begin
            bad++; $display("FAIL gap_steady: got i=%0d q=%0d want 16224 0", $signed(out_i), $signed(out_q));
          end
          total++;
        end
      end
    end
    if (n_out != 4) begin bad++; $display("FAIL gap_count: got %0d want 4", n_out); end
    total++;
    if (t_last - t_prev != 2*DEC) begin bad++; $display("FAIL gap_period: got %0d want %0d", t_last - t_prev, 2*DEC); end
    total++;
  endtask

  task automatic test_clken_gap();
    int n_out = 0, k3 = 0;
    logic [OUT_W-1:0] held_i, held_q;
    logic ce;
    held_i = '0; held_q = '0;
    pulse_reset();
    for (int k = 1; k <= 360; k++) begin
      ce = !(k >= 159 && k < 169);
      tick(ce, 1'b1, 8'hFF, NCO_W'(200), NCO_W'(511));
      if ({out_valid, out_i, out_q} !== {exp_vis, exp_i, exp_q}) begin
        bad++;
        $display("FAIL ce_model k=%0d: got v=%b i=%0d q=%0d want v=%b i=%0d q=%0d", k,
                 out_valid, $signed(out_i), $signed(out_q), exp_vis, $signed(exp_i), $signed(exp_q));
      end
      total++;
      if (k == 158) begin held_i = out_i; held_q = out_q; end
      if (!ce) begin
        if (out_valid !== 1'b0 || out_i !== held_i || out_q !== held_q) begin
          bad++; $display("FAIL ce_frozen k=%0d: got v=%b i=%0d want v=0 i=%0d", k, out_valid, $signed(out_i), $signed(held_i));
        end
        total++;
      end
      if (out_valid) begin
        n_out++;
        if (n_out == 3) k3 = k;
      end
    end
    if (k3 != 3*DEC+6+10) begin bad++; $display("FAIL ce_shift: third output at %0d want %0d", k3, 3*DEC+16); end
    total++;
    if (n_out != 5) begin bad++; $display("FAIL ce_count: got %0d want 5", n_out); end
    total++;
  endtask

  task automatic test_reset_mid();
    int first = 0;
    pulse_reset();
    for (int t = 0; t < 100; t++) tick(1'b1, 1'b1, 8'hFF, NCO_W'(300), NCO_W'(511));
    if (out_i === '0) begin bad++; $display("FAIL rst_mid_pre: got i=0 want nonzero before reset"); end
    total++;
    pulse_reset();
    if (out_valid !== 1'b0 || out_i !== '0 || out_q !== '0) begin
      bad++; $display("FAIL rst_mid_async: got v=%b i=%0d q=%0d want 0 0 0", out_valid, $signed(out_i), $signed(out_q));
    end
    total++;
    for (int k = 1; k <= 80; k++) begin
      tick(1'b1, 1'b1, 8'hFF, NCO_W'(300), NCO_W'(511));
      if ({out_valid, out_i, out_q} !== {exp_vis, exp_i, exp_q}) begin
        bad++;
        $display("FAIL rst_mid_model k=%0d: got v=%b i=%0d q=%0d want v=%b i=%0d q=%0d", k,
                 out_valid, $signed(out_i), $signed(out_q), exp_vis, $signed(exp_i), $signed(exp_q));
      end
      total++;
      if (out_valid && first == 0) first = k;
    end
    if (first != DEC+6) begin bad++; $display("FAIL rst_mid_latency: first out at %0d want %0d", first, DEC+6); end
    total++;
  endtask

  task automatic test_random();
    pulse_reset();
    for (int t = 0; t < 1500; t++) begin
      tick(($urandom % 5) != 0, ($urandom % 4) != 0, ADC_W'($urandom), NCO_W'($urandom), NCO_W'($urandom));
      if ({out_valid, out_i, out_q} !== {exp_vis, exp_i, exp_q}) begin
        bad++;
        $display("FAIL rand_model tick=%0d: got v=%b i=%0d q=%0d want v=%b i=%0d q=%0d", tick_n,
                 out_valid, $signed(out_i), $signed(out_q), exp_vis, $signed(exp_i), $signed(exp_q));
      end
      total++;
    end
  endtask

  initial begin
    reset_n = 1'b0; clken = 1'b0; nco_valid_i = 1'b0;
    adc_i = '0; nco_sin_i = '0; nco_cos_i = '0;
    p_ce = 1'b0; p_vl = 1'b0; p_a = '0; p_s = '0; p_c = '0;
    exp_ov = 1'b0; exp_vis = 1'b0; exp_i = '0; exp_q = '0;
    acc = 0; en_edges = 0;
    build_h();
    test_reset();
    test_dc_pos();
    test_dc_neg();
    test_midscale();
    test_gapped();
    test_clken_gap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddc_mixer_cic.md
Name: ddc_mixer_cic

Overview:
Digital down-converter stage directly downstream of the quadrature NCO (mnco). Converts each offset-binary ADC sample to signed and multiplies it by the NCO cos/sin outputs to form I/Q. Each channel then goes through a 3-stage CIC decimator, producing baseband I/Q at Fs/DEC for the demodulator.

Parameters:
ADC_W, 8, ADC sample width, offset binary.
NCO_W, 10, NCO sin/cos width, signed two's complement.
DEC, 64, decimation ratio; must be a power of two.
DEC_LOG2, 6, log2(DEC).
OUT_W, 16, output I/Q width, signed.

Ports:
clk  in  1  system clock, same clock as the NCO.
reset_n  in  1  asynchronous active-low reset.
clken  in  1  global clock enable, shared with the NCO; the whole block holds state when 0.
adc_i  in  ADC_W  ADC sample, offset binary.
nco_valid_i  in  1  NCO out_valid.
nco_sin_i  in  NCO_W  NCO fsin_o.
nco_cos_i  in  NCO_W  NCO fcos_o.
out_i  out  OUT_W  decimated in-phase sample, signed.
out_q  out  OUT_W  decimated quadrature sample, signed.
out_valid  out  1  one-cycle strobe; out_i/out_q are valid when it is high.

Behaviour:
- One clock, clk. reset_n is asynchronous and active-low. While reset_n=0, every register is 0: out_i=0, out_q=0, out_valid=0, decimation counter=0, integrators and comb delays=0.
- Accept: in_ok = clken & nco_valid_i. When clken=0, every register holds its value, out_valid=0, and outputs stay stable.
- Pipeline: each step below advances only on clken=1.
  - E0, capture: adc_s = adc_i with MSB inverted (signed), plus sin and cos. A valid bit marks the captured sample.
  - E1, multiply: pi = adc_s*cos, pq = adc_s*sin; product width ADC_W+NCO_W = 18 bits.
  - E2..E4: three registered integrators, each updated only when its input valid bit is set.
- Width: CIC_W = ADC_W+NCO_W+3*DEC_LOG2 (36 by default). Sign-extend products to CIC_W. Integrators wrap modulo 2^CIC_W; the wrap is intended and is not an error.
- Decimation counter:
  - Range 0..DEC-1; increments on each integrator-3 update.
  - When it is DEC-1 at the moment of an update, raise the decimation strobe and wrap the counter to 0.
- Comb section: on the decimation strobe, run three combs (y = x - x_prev, differential delay 1) combinationally from the integrator-3 value.
  - Register the result into the output on the next enabled edge, E5, and pulse out_valid for exactly one cycle.
  - Update comb delay registers only on the strobe.
- Output: out = comb3[CIC_W-1 -: OUT_W]. Plain truncation: arithmetic shift right by CIC_W-OUT_W, no rounding, no saturation.
- Latency: 5 enabled clocks from acceptance of the DEC-th sample to out_valid.
- Rate: exactly one out_valid per DEC accepted samples, independent of gaps in nco_valid_i or clken.
- Reset mid-operation: asynchronously clears everything. The first output after reset needs a full DEC accepted samples.
- I and Q share the valid pipeline and counter, so they are always co-timed.

Decomposition:
- Package ddc_pkg: ADC_W, NCO_W, DEC_LOG2, OUT_W defaults; derived CIC_W; function for offset-binary-to-signed conversion.
- Sub-module cic_dec3: one channel of the 3 integrators plus 3 combs. Inputs: product, product valid, decimation strobe. Instantiated twice, for I and Q.
- The top level holds the capture/multiply stages, the decimation counter and the output registers.

Test Plan:
1. DC positive: adc_i=8'hFF (+127), cos=511, sin=0, nco_valid_i=1 continuously -> out_valid every 64 clocks; from the 4th output onward out_i=16224, out_q=0.
2. DC negative: adc_i=8'h00 (-128), cos=511, sin=0 -> steady out_i=-16352, out_q=0. Swap to sin=511, cos=0 -> out_q=-16352, out_i=0.
3. Midscale: adc_i=8'h80, any sin/cos -> out_i=out_q=0 for every out_valid.
4. Gapped input: nco_valid_i toggles every cycle, stimulus as in test 1 -> out_valid period 128 clocks, same steady values as test 1.
5. clken=0 for 10 cycles mid-run -> no out_valid and outputs frozen during the gap; after it, output sequence identical to an uninterrupted run, shifted by 10 cycles.
6. reset_n pulsed low for 1 cycle mid-decimation -> outputs and out_valid 0 immediately (asynchronous); next out_valid exactly 64 accepted samples + 5 clocks after release.
